// File: rtl/instr_loader.sv
// instr_loader: boot-time instruction-memory loader.
// Packs a valid/ready byte stream into big-endian 32-bit words and writes them
// to consecutive word addresses starting at BASE_ADDR. The core is held until
// the requested number of words has been written.
module instr_loader #(
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH:0]   count_q;

  // Bytes are only taken while collecting; decoded straight from the state so
  // the source sees ready in the same cycle the FSM enters COLLECT.
  assign byte_ready = (state == S_COLLECT);

  // Load sequencer: state, byte packing, write strobe and status flags.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // a blocking assignment would let later statements observe the new state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      byte_idx     <= '0;
      word_idx     <= '0;
      count_q      <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_loaded <= '0;
    end else begin
      // NOTE: the write strobe defaults low each cycle and is raised only on
      // entry to WRITE, which makes it a single-cycle pulse by construction.
      imem_we <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            count_q      <= word_count;
            words_loaded <= '0;
            byte_idx     <= '0;
            word_idx     <= '0;
            if (word_count == '0) begin
              state    <= S_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
            end else begin
              state    <= S_COLLECT;
              done     <= 1'b0;
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end

        S_COLLECT: begin
          if (byte_valid) begin
            // Shifting in from the LSB leaves the first byte in [31:24]
            // once four bytes have arrived.
            imem_wdata <= {imem_wdata[23:0], byte_data};
            byte_idx   <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state     <= S_WRITE;
              imem_we   <= 1'b1;
              imem_addr <= BASE_ADDR + word_idx;
            end
          end
        end

        S_WRITE: begin
          words_loaded <= words_loaded + 1'b1;
          word_idx     <= word_idx + 1'b1;
          byte_idx     <= '0;
          if (words_loaded + 1'b1 == count_q) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state <= S_COLLECT;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized self-checking bench for instr_loader.
// Two instances share one stimulus stream: the default configuration and a
// 2-bit address space with a nonzero base, so address wrap is exercised.
module tb_instr_loader;

  localparam int AW_A   = 10;
  localparam int BASE_A = 0;
  localparam int AW_B   = 2;
  localparam int BASE_B = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [AW_A:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic            byte_ready, imem_we, cpu_hold, busy, done;
  logic [AW_A-1:0] imem_addr;
  logic [31:0]     imem_wdata;
  logic [AW_A:0]   words_loaded;

  logic            b_byte_ready, b_imem_we, b_cpu_hold, b_busy, b_done;
  logic [AW_B-1:0] b_imem_addr;
  logic [31:0]     b_imem_wdata;
  logic [AW_B:0]   b_words_loaded;

  int errors = 0;
  int checks = 0;

  logic [7:0] fixed_bytes[$];

  always #5 clk = ~clk;

  instr_loader #(.ADDR_WIDTH(AW_A), .BASE_ADDR(AW_A'(BASE_A))) dut_a (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .words_loaded(words_loaded)
  );

  instr_loader #(.ADDR_WIDTH(AW_B), .BASE_ADDR(AW_B'(BASE_B))) dut_b (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count[AW_B:0]),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(b_byte_ready),
    .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .cpu_hold(b_cpu_hold), .busy(b_busy), .done(b_done),
    .words_loaded(b_words_loaded)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: pulses reset for one edge and checks reset values.
  task automatic do_reset();
    reset = 1'b1;
    byte_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_ready", byte_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, BASE_A);
    check("rst_addr_b", b_imem_addr, BASE_B);
    check("rst_wdata", imem_wdata, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_loaded", words_loaded, 0);
    reset = 1'b0;
  endtask

  task automatic pulse_start(input int count);
    start = 1'b1;
    word_count = (AW_A + 1)'(count);
    @(negedge clk);
    start = 1'b0;
    word_count = (AW_A + 1)'($urandom);
    check("st_we", imem_we, 0);
    check("st_loaded", words_loaded, 0);
    if (count == 0) begin
      check("zero_done", done, 1);
      check("zero_hold", cpu_hold, 0);
      check("zero_busy", busy, 0);
      check("zero_ready", byte_ready, 0);
    end else begin
      check("st_busy", busy, 1);
      check("st_hold", cpu_hold, 1);
      check("st_done", done, 0);
      check("st_ready", byte_ready, 1);
    end
  endtask

  // Presents one byte and returns at the negedge after it is accepted.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    byte_valid = 1'b1;
    byte_data = b;
    while (!byte_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!byte_ready) begin
      check("byte_timeout", 0, 1);
      byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data = 8'($urandom);
  endtask

  // Full load of 'count' words with random valid gaps; optionally pulses an
  // extra start (with a different count) while collecting the first word.
  task automatic load(input int count, input int max_gap, input bit poke_start);
    logic [7:0] bytes [4];
    logic [31:0] exp_word;
    int gap;
    pulse_start(count);
    for (int w = 0; w < count; w++) begin
      for (int k = 0; k < 4; k++) begin
        gap = $urandom_range(0, max_gap);
        if (poke_start && w == 0 && k == 1) gap = 2;
        for (int g = 0; g < gap; g++) begin
          byte_valid = 1'b0;
          byte_data = 8'($urandom);
          if (poke_start && w == 0 && k == 1 && g == 0) begin
            start = 1'b1;
            word_count = (AW_A + 1)'(count + 3);
          end
          @(negedge clk);
          start = 1'b0;
          check("gap_ready", byte_ready, 1);
          check("gap_we", imem_we, 0);
          check("gap_busy", busy, 1);
        end
        if (fixed_bytes.size() > 0) bytes[k] = fixed_bytes.pop_front();
        else bytes[k] = 8'($urandom);
        send_byte(bytes[k]);
      end
      exp_word = {bytes[0], bytes[1], bytes[2], bytes[3]};
      check("wr_we", imem_we, 1);
      check("wr_addr", imem_addr, (BASE_A + w) % (1 << AW_A));
      check("wr_data", imem_wdata, exp_word);
      check("wr_we_b", b_imem_we, 1);
      check("wr_addr_b", b_imem_addr, (BASE_B + w) % (1 << AW_B));
      check("wr_data_b", b_imem_wdata, exp_word);
      check("wr_ready", byte_ready, 0);
      check("wr_hold", cpu_hold, 1);
      @(negedge clk);
      check("post_we", imem_we, 0);
      check("post_loaded", words_loaded, w + 1);
      if (w == count - 1) begin
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_hold", cpu_hold, 0);
        check("end_ready", byte_ready, 0);
        check("end_wdata", imem_wdata, exp_word);
      end else begin
        check("mid_ready", byte_ready, 1);
        check("mid_done", done, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data = '0;
    @(negedge clk);
    do_reset();

    // Directed stream: two words, valid held high.
    fixed_bytes = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
    load(2, 0, 1'b0);

    // Zero-length load straight from reset.
    do_reset();
    pulse_start(0);
    @(negedge clk);
    check("zero_stay_done", done, 1);
    check("zero_stay_we", imem_we, 0);

    // Single word with three-cycle valid gaps.
    do_reset();
    for (int k = 0; k < 4; k++) fixed_bytes.push_back(8'($urandom));
    load(1, 3, 1'b0);

    // Reset after two bytes of the second word, then a fresh one-word load.
    do_reset();
    pulse_start(2);
    for (int k = 0; k < 4; k++) send_byte(8'($urandom));
    @(negedge clk);
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset();
    @(negedge clk);
    check("rst_hold_we", imem_we, 0);
    load(1, 0, 1'b0);

    // Start ignored while collecting; then back-to-back random loads
    // restarted from DONE, covering address wrap on the small instance.
    load(2, 1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      load($urandom_range(1, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time loader that fills instruction memory before the single-cycle core runs.
- Accepts a byte stream over a valid/ready handshake and packs each group of four bytes into a big-endian 32-bit instruction word.
- Writes each word to sequential instruction-memory word addresses.
- Holds the core in hold until the requested word count is written; its output is the opcode/instruction source the control decoder later consumes.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written (ADDR_WIDTH bits).

Ports:
- clk, input, 1, single clock; all state changes on rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- word_count, input, ADDR_WIDTH+1, number of words to load; latched on accepted start.
- byte_valid, input, 1, byte_data is valid.
- byte_data, input, 8, stream byte.
- byte_ready, output, 1, loader accepts a byte this cycle.
- imem_we, output, 1, instruction-memory write strobe.
- imem_addr, output, ADDR_WIDTH, word address of the write.
- imem_wdata, output, 32, instruction word.
- cpu_hold, output, 1, high keeps the core stalled or in reset.
- busy, output, 1, load in progress.
- done, output, 1, load complete; stays high until the next start.
- words_loaded, output, ADDR_WIDTH+1, count of words written in the current or last load.

Behaviour:
- Reset (synchronous, takes priority over all inputs):
  - state=IDLE, byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - cpu_hold=1, busy=0, done=0, words_loaded=0.
  - Internal byte index=0, word index=0.
  - Reset mid-load abandons the partial word; no write occurs.
- States are IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - byte_ready=0, cpu_hold=1.
  - On start: latch word_count and clear words_loaded.
  - If word_count=0, go to DONE next cycle. Otherwise go to COLLECT, busy=1.
- COLLECT:
  - byte_ready=1.
  - A byte transfers when byte_valid & byte_ready at a clock edge.
  - Byte k (k=0..3) goes to imem_wdata[31-8k:24-8k], so the first byte is the MSB (big-endian).
  - After the 4th transfer, go to WRITE. byte_ready is combinationally 1 throughout COLLECT; no bytes are accepted in any other state.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=BASE_ADDR+word index (modulo 2^ADDR_WIDTH), imem_wdata holds the packed word.
  - Next cycle: word index+1, words_loaded+1.
  - If the new words_loaded equals the latched count, go to DONE. Otherwise return to COLLECT with byte index=0.
- Latency and throughput:
  - imem_we asserts the cycle after the 4th byte is accepted.
  - Peak rate is one word per 5 cycles.
- DONE:
  - done=1, busy=0, cpu_hold=0, byte_ready=0.
  - imem_wdata and imem_addr keep their last values.
  - A start pulse behaves as in IDLE: cpu_hold=1 and done=0 from the next cycle, indices reset.
- start while busy (COLLECT or WRITE) is ignored.
- byte_valid with byte_ready=0 is ignored; the source must hold the byte.
- word_count greater than 2^ADDR_WIDTH: addresses wrap modulo 2^ADDR_WIDTH and the loader still writes the full count.
- Gaps in byte_valid stall COLLECT indefinitely with no timeout.
- imem_we is never high outside WRITE.

Test Plan:
- Reset then start, word_count=2, bytes 8C,01,00,04,AC,02,00,08 with valid always high -> imem_we pulses twice: addr 0 data 8C010004, addr 1 data AC020008. done=1, cpu_hold=0, words_loaded=2. Each write occurs one cycle after its 4th byte.
- start with word_count=0 -> DONE one cycle after IDLE, no imem_we, done=1, cpu_hold drops.
- word_count=1, bytes delivered with 3-cycle valid gaps between them -> a single write of the correct word only after the 4th byte. byte_ready stays high throughout COLLECT.
- Assert reset after 2 bytes of the second word -> no write, all outputs at reset values. A subsequent start with count 1 writes addr 0 with the new bytes only.
- ADDR_WIDTH=2, BASE_ADDR=3, word_count=2 -> writes to addr 3 then addr 0 (wrap).
- start pulse while in COLLECT -> ignored, count unchanged. start in DONE -> cpu_hold returns to 1, done clears, and a new load begins at BASE_ADDR.
